// File: rtl/flash_cmd_sequencer.sv
// Command sequencer between the RX command decoder, a single-access flash port and the TX sender.
// Reads stream cmd_len+1 beats to TX; writes send one ACK word; each access is guarded by a timeout.
module flash_cmd_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 1023,
  parameter     ACK_CODE    = 8'hA5
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              fl_start,
  output logic              fl_we,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [DATA_W-1:0] fl_wdata,
  input  logic [DATA_W-1:0] fl_rdata,
  input  logic              fl_done,
  output logic              tx_trig,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ACK_WORD = DATA_W'(ACK_CODE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_FL,
    S_TX_SEND
  } state_t;

  state_t state, state_nxt;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  rem_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;

  // Timeout fires on the TIMEOUT_CYC-th WAIT_FL cycle; fl_done in that same cycle still completes.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_valid) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT_FL;
      S_WAIT_FL: begin
        if (fl_done)      state_nxt = S_TX_SEND;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_TX_SEND: begin
        if (!tx_busy) state_nxt = (rem_q == '0) ? S_IDLE : S_ISSUE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      tmo_cnt     <= '0;
      tx_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            wr_q        <= cmd_write;
            addr_q      <= cmd_addr;
            data_q      <= cmd_data;
            rem_q       <= cmd_write ? '0 : cmd_len;
            err_timeout <= 1'b0;
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT_FL: begin
          if (fl_done)      tx_data     <= wr_q ? ACK_WORD : fl_rdata;
          else if (tmo_hit) err_timeout <= 1'b1;
          else              tmo_cnt     <= tmo_cnt + 1'b1;
        end
        S_TX_SEND: begin
          if (!tx_busy && rem_q != '0) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // tx_trig is qualified by tx_busy so the send fires in the first free TX_SEND cycle.
  always_comb begin
    cmd_ready = 1'b0;
    fl_start  = 1'b0;
    fl_we     = 1'b0;
    fl_addr   = '0;
    fl_wdata  = '0;
    tx_trig   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:    cmd_ready = 1'b1;
      S_ISSUE: begin
        fl_start = 1'b1;
        fl_we    = wr_q;
        fl_addr  = addr_q;
        fl_wdata = data_q;
      end
      S_WAIT_FL: begin
        fl_we    = wr_q;
        fl_addr  = addr_q;
        fl_wdata = data_q;
      end
      S_TX_SEND: tx_trig = !tx_busy;
      default: ;
    endcase
  end

endmodule
